// File: rtl/share_unmasker_if.sv
// Share-beat input and unmasked-word output handshakes of the unmasker.
interface share_unmasker_if #(
   parameter int WIDTH = 256
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_share;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid,
      output in_share,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_share,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/share_unmasker.sv
// XOR-recombines SHARES serially delivered shares into one plaintext word.
module share_unmasker #(
   parameter int SHARES = 3,
   parameter int WIDTH  = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   share_unmasker_if.slave bus,
   output logic           busy
);

   localparam int CW = $clog2(SHARES);
   localparam logic [CW-1:0] LAST = CW'(SHARES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_n;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_n;
   logic             beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
      end
   end

   assign beat = bus.in_valid & bus.in_ready;

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (beat) begin
               acc_n   = bus.in_share;
               cnt_n   = CW'(1);
               state_n = ACC;
            end
         end
         ACC: begin
            if (beat) begin
               acc_n = acc ^ bus.in_share;
               cnt_n = cnt + CW'(1);
               if (cnt == LAST) state_n = OUT;
            end
         end
         OUT: begin
            // scrub the recombined word once it has been handed off
            if (bus.out_ready) begin
               acc_n   = '0;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: begin
            acc_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
      if (flush) begin
         acc_n   = '0;
         cnt_n   = '0;
         state_n = IDLE;
      end
   end

   // partial sums never reach the port; only a finished word is exposed
   assign bus.in_ready  = rst_n & (state != OUT);
   assign bus.out_valid = (state == OUT);
   assign bus.out_data  = (state == OUT) ? acc : '0;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_share_unmasker.sv
// Scoreboard bench for share_unmasker: directed words plus random SHARES=2..4 runs.
module tb_share_unmasker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   share_unmasker_if #(.WIDTH(8)) u ();

   share_unmasker #(.SHARES(3), .WIDTH(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flush),
      .bus  (u.slave),
      .busy (busy)
   );

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   bit rnd_or = 1'b0;
   bit go_rand = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (u.out_valid && u.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected actual=%0h required=none",
                        u.out_data);
            end else begin
               chk("word", {24'd0, u.out_data}, {24'd0, exp_q.pop_front()});
            end
         end
         if (!u.out_valid) chk("gate", {24'd0, u.out_data}, 32'd0);
      end
   end

   always @(posedge clk) begin
      if (rnd_or) begin
         #1;
         u.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic beat(input logic [7:0] d);
      int n;
      logic r;
      n = 0;
      u.in_valid = 1'b1;
      u.in_share = d;
      do begin
         @(negedge clk);
         r = u.in_ready;
         @(posedge clk);
         n++;
      end while (!r && n < 200);
      #1;
      u.in_valid = 1'b0;
      if (!r) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=in_ready_low required=accept");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 2; g++) begin : gx
      localparam int S = (g == 0) ? 2 : 4;
      share_unmasker_if #(.WIDTH(8)) v ();
      logic bz;
      bit fin = 1'b0;
      logic [7:0] q[$];

      share_unmasker #(.SHARES(S), .WIDTH(8)) d (
         .clk  (clk),
         .rst_n(rst_n),
         .flush(1'b0),
         .bus  (v.slave),
         .busy (bz)
      );

      always @(negedge clk) begin
         if (rst_n && go_rand) begin
            if (v.out_valid && v.out_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL gx%0d_unexpected actual=%0h required=none",
                           S, v.out_data);
               end else begin
                  chk($sformatf("gx%0d_word", S), {24'd0, v.out_data},
                      {24'd0, q.pop_front()});
               end
            end
            if (!v.out_valid)
               chk($sformatf("gx%0d_gate", S), {24'd0, v.out_data}, 32'd0);
         end
      end

      always @(posedge clk) begin
         if (go_rand) begin
            #1;
            v.out_ready = fin ? 1'b1 : 1'($urandom_range(0, 1));
         end
      end

      initial begin
         logic [7:0] x;
         logic [7:0] r;
         logic rd;
         int n;
         v.in_valid = 1'b0;
         v.in_share = '0;
         v.out_ready = 1'b0;
         wait (go_rand);
         @(posedge clk);
         #1;
         for (int w = 0; w < 20; w++) begin
            x = '0;
            for (int j = 0; j < S; j++) begin
               r = 8'($urandom_range(0, 255));
               x ^= r;
               if (j == S - 1) q.push_back(x);
               v.in_valid = 1'b1;
               v.in_share = r;
               n = 0;
               do begin
                  @(negedge clk);
                  rd = v.in_ready;
                  @(posedge clk);
                  n++;
               end while (!rd && n < 200);
               #1;
               v.in_valid = 1'b0;
               if (!rd) begin
                  checks++;
                  failures++;
                  $display("FAIL gx%0d_beat_timeout actual=in_ready_low required=accept", S);
               end
               if ($urandom_range(0, 2) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
         n = 0;
         while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
         end
         chk($sformatf("gx%0d_drain", S), q.size(), 32'd0);
         fin = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] x;
      logic [7:0] r;
      int n;
      u.in_valid = 1'b0;
      u.in_share = '0;
      u.out_ready = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, u.out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, u.out_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", {31'd0, u.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // basic word and one-cycle latency
      u.out_ready = 1'b1;
      exp_q.push_back(8'hA5);
      beat(8'h96);
      beat(8'h3C);
      beat(8'h0F);
      @(negedge clk);
      chk("lat_valid", {31'd0, u.out_valid}, 32'd1);
      chk("lat_data", {24'd0, u.out_data}, 32'hA5);
      chk("lat_in_ready", {31'd0, u.in_ready}, 32'd0);
      @(negedge clk);
      chk("basic_done_valid", {31'd0, u.out_valid}, 32'd0);
      chk("basic_done_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;

      // backpressure
      u.out_ready = 1'b0;
      exp_q.push_back(8'hA5);
      beat(8'h96);
      beat(8'h3C);
      beat(8'h0F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, u.out_valid}, 32'd1);
         chk("bp_data", {24'd0, u.out_data}, 32'hA5);
         chk("bp_in_ready", {31'd0, u.in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      u.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);
      chk("bp_idle_in_ready", {31'd0, u.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // gaps between beats
      exp_q.push_back(8'h77);
      beat(8'h11);
      @(negedge clk);
      chk("gap_busy", {31'd0, busy}, 32'd1);
      chk("gap_valid", {31'd0, u.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      idle(2);
      beat(8'h22);
      idle(1);
      beat(8'h44);
      idle(2);

      // flush drops the partial word and the simultaneous beat
      beat(8'hFF);
      beat(8'h01);
      u.in_valid = 1'b1;
      u.in_share = 8'h55;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      u.in_valid = 1'b0;
      @(negedge clk);
      chk("fl_busy", {31'd0, busy}, 32'd0);
      chk("fl_in_ready", {31'd0, u.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      exp_q.push_back(8'h0D);
      beat(8'h0A);
      beat(8'h0B);
      beat(8'h0C);
      idle(2);

      // flush drops a pending output word
      u.out_ready = 1'b0;
      beat(8'h12);
      beat(8'h34);
      beat(8'h56);
      @(negedge clk);
      chk("flo_valid", {31'd0, u.out_valid}, 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flo_dropped", {31'd0, u.out_valid}, 32'd0);
      chk("flo_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      u.out_ready = 1'b1;

      // reset mid-word
      beat(8'h96);
      beat(8'h3C);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, u.out_valid}, 32'd0);
      chk("mid_rst_data", {24'd0, u.out_data}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back(8'hA5);
      beat(8'h96);
      beat(8'h3C);
      beat(8'h0F);
      idle(3);

      // random words with random backpressure
      rnd_or = 1'b1;
      go_rand = 1'b1;
      for (int w = 0; w < 30; w++) begin
         x = '0;
         for (int j = 0; j < 3; j++) begin
            r = 8'($urandom_range(0, 255));
            x ^= r;
            if (j == 2) exp_q.push_back(x);
            beat(r);
            if ($urandom_range(0, 2) == 0) idle(1);
         end
      end
      rnd_or = 1'b0;
      @(posedge clk);
      #2;
      u.out_ready = 1'b1;
      idle(10);
      n = 0;
      while (!(gx[0].fin && gx[1].fin) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      if (!(gx[0].fin && gx[1].fin)) begin
         checks++;
         failures++;
         $display("FAIL gx_timeout actual=unfinished required=finished");
      end
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
